// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the sequential ALU.
// Optional divider datapath is enabled with the ALU_SEQ_DIV_EN macro.
package alu_seq_pkg;

  localparam int unsigned FN_W = 11;

  // Bit positions inside the one-hot function select
  localparam int unsigned FN_PASSY = 0;
  localparam int unsigned FN_ADD   = 1;
  localparam int unsigned FN_SUB   = 2;
  localparam int unsigned FN_MUL   = 3;
  localparam int unsigned FN_DIV   = 4;
  localparam int unsigned FN_AND   = 5;
  localparam int unsigned FN_OR    = 6;
  localparam int unsigned FN_NOTY  = 7;
  localparam int unsigned FN_SHL   = 8;
  localparam int unsigned FN_SHR   = 9;
  localparam int unsigned FN_NOTX  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: shared WIDTH-step shift register for shift-add multiply and
// restoring divide. Divide path only exists when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] res_c,
  output logic             hi_nz_c
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] hi_n, lo_n;

`ifdef ALU_SEQ_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rem_sh, rem_dif;

  // One step of either algorithm; hi holds partial product or remainder
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_dif = rem_sh - {1'b0, b_q};
    if (div_q) begin
      if (rem_dif[WIDTH]) begin
        hi_n = rem_sh[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_n = rem_dif[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end
`else
  logic unused_op_div;
  assign unused_op_div = op_div;

  // One shift-add multiply step; hi holds the upper partial product
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    hi_n    = mul_sum[WIDTH:1];
    lo_n    = {mul_sum[0], lo_q[WIDTH-1:1]};
  end
`endif

  assign last_c  = (cnt_q == CNT_W'(WIDTH - 1));
  assign res_c   = lo_n;
  assign hi_nz_c = |hi_n;

  // Load operands on accept, then advance one bit per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      cnt_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= op_div;
`endif
    end else if (step) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential accumulator ALU with start/done handshake, iterative
// multiply/divide and registered flags. Divider enabled by ALU_SEQ_DIV_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FN_W-1:0]  fn,
  input  logic             c7,
  input  logic             c14,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] x_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_e
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_c, y_c;
  logic             fn_ok_c, iter_op_c;
  logic [WIDTH:0]   add_c, sub_c;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cy, sc_err;
  logic             iter_load, upd;
  logic [WIDTH-1:0] res_d;
  logic             cy_d, err_d;
  logic             it_last_c, it_hi_nz_c;
  logic [WIDTH-1:0] it_res_c;
  logic             it_div;

`ifdef ALU_SEQ_DIV_EN
  logic             div_q, yzero_q;
  assign it_div = div_q;
`else
  assign it_div = 1'b0;
`endif

  // Operand zeroing and single-cycle function evaluation
  always_comb begin
    x_c     = c7  ? '0 : acc_in;
    y_c     = c14 ? '0 : x_in;
    fn_ok_c = $onehot(fn);
`ifdef ALU_SEQ_DIV_EN
    iter_op_c = fn_ok_c && (fn[FN_MUL] || fn[FN_DIV]);
`else
    iter_op_c = fn_ok_c && fn[FN_MUL];
`endif
    add_c  = {1'b0, x_c} + {1'b0, y_c};
    sub_c  = {1'b0, x_c} - {1'b0, y_c};
    sc_res = '0;
    sc_cy  = 1'b0;
    sc_err = 1'b0;
    if (!fn_ok_c) begin
      sc_err = 1'b1;
    end else if (fn[FN_PASSY]) begin
      sc_res = y_c;
    end else if (fn[FN_ADD]) begin
      sc_res = add_c[WIDTH-1:0];
      sc_cy  = add_c[WIDTH];
    end else if (fn[FN_SUB]) begin
      sc_res = sub_c[WIDTH-1:0];
      sc_cy  = sub_c[WIDTH];
    end else if (fn[FN_AND]) begin
      sc_res = x_c & y_c;
    end else if (fn[FN_OR]) begin
      sc_res = x_c | y_c;
    end else if (fn[FN_NOTY]) begin
      sc_res = ~y_c;
    end else if (fn[FN_SHL]) begin
      sc_res = {x_c[WIDTH-2:0], 1'b0};
      sc_cy  = x_c[WIDTH-1];
    end else if (fn[FN_SHR]) begin
      sc_res = {1'b0, x_c[WIDTH-1:1]};
      sc_cy  = x_c[0];
    end else if (fn[FN_NOTX]) begin
      sc_res = ~x_c;
    end else begin
      // divide without a divider lands here and reports an error
      sc_err = 1'b1;
    end
  end

  // Next-state and result/flag update selection
  always_comb begin
    state_d   = state_q;
    iter_load = 1'b0;
    upd       = 1'b0;
    res_d     = sc_res;
    cy_d      = sc_cy;
    err_d     = sc_err;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (iter_op_c) begin
            state_d   = RUN;
            iter_load = 1'b1;
          end else begin
            state_d = DONE;
            upd     = 1'b1;
          end
        end
      end
      RUN: begin
        if (it_last_c) begin
          state_d = DONE;
          upd     = 1'b1;
          res_d   = it_res_c;
`ifdef ALU_SEQ_DIV_EN
          cy_d    = div_q ? 1'b0 : it_hi_nz_c;
          err_d   = div_q & yzero_q;
`else
          cy_d    = it_hi_nz_c;
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, handshake and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_c  <= 1'b0;
      flag_e  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      if (upd) begin
        result <= res_d;
        flag_z <= (res_d == '0);
        flag_n <= res_d[WIDTH-1];
        flag_c <= cy_d;
        flag_e <= err_d;
      end
    end
  end

`ifdef ALU_SEQ_DIV_EN
  // Remember op kind and divide-by-zero for the end of the iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= 1'b0;
      yzero_q <= 1'b0;
    end else if (iter_load) begin
      div_q   <= fn[FN_DIV];
      yzero_q <= (y_c == '0);
    end
  end
`endif

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (iter_load),
    .step    (state_q == RUN),
    .op_div  (it_div),
    .a       (x_c),
    .b       (y_c),
    .last_c  (it_last_c),
    .res_c   (it_res_c),
    .hi_nz_c (it_hi_nz_c)
  );

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=16.
// Divide vectors depend on ALU_SEQ_DIV_EN.
module tb_alu_seq;

  localparam logic [10:0] F_PASSY = 11'b00000000001;
  localparam logic [10:0] F_ADD   = 11'b00000000010;
  localparam logic [10:0] F_SUB   = 11'b00000000100;
  localparam logic [10:0] F_MUL   = 11'b00000001000;
  localparam logic [10:0] F_DIV   = 11'b00000010000;
  localparam logic [10:0] F_AND   = 11'b00000100000;
  localparam logic [10:0] F_OR    = 11'b00001000000;
  localparam logic [10:0] F_NOTY  = 11'b00010000000;
  localparam logic [10:0] F_SHL   = 11'b00100000000;
  localparam logic [10:0] F_SHR   = 11'b01000000000;
  localparam logic [10:0] F_NOTX  = 11'b10000000000;

  logic        clk, rst, start, c7, c14;
  logic [10:0] fn;
  logic [15:0] acc_in, x_in, result;
  logic        busy, done, flag_z, flag_n, flag_c, flag_e;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  int lat, bcnt, dcount;

  assign flags = {flag_z, flag_n, flag_c, flag_e};

  alu_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .fn     (fn),
    .c7     (c7),
    .c14    (c14),
    .acc_in (acc_in),
    .x_in   (x_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_c (flag_c),
    .flag_e (flag_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at #1 after an edge; return edges until done and busy cycles.
  // A second start is pulsed at latency 'poke' to show it is ignored.
  task automatic do_op(input logic [10:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic z7, input logic z14, input int poke,
                       output int l, output int bc);
    fn = f; acc_in = a; x_in = b; c7 = z7; c14 = z14; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc_in = ~a; x_in = ~b; fn = ~f; c7 = ~z7; c14 = ~z14;
    l = 1; bc = 0;
    while (!done && l < 40) begin
      if (busy) bc++;
      start = (l == poke);
      if (l == poke) fn = F_ADD;
      @(posedge clk); #1;
      start = 1'b0;
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fn = '0; c7 = 1'b0; c14 = 1'b0;
    acc_in = '0; x_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_done",   32'(done),   32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_flags",  32'(flags),  32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // add
    do_op(F_ADD, 16'h0003, 16'h0004, 1'b0, 1'b0, -1, lat, bcnt);
    check("add_res",   32'(result), 32'h0007);
    check("add_lat",   32'(lat),    32'd1);
    check("add_busy",  32'(bcnt),   32'd0);
    check("add_flags", 32'(flags),  32'h0);
    @(posedge clk); #1;
    check("add_done_pulse", 32'(done), 32'h0);

    // subtract with borrow
    do_op(F_SUB, 16'h0003, 16'h0005, 1'b0, 1'b0, -1, lat, bcnt);
    check("sub_res",   32'(result), 32'hFFFE);
    check("sub_flags", 32'(flags),  32'b0110);
    @(posedge clk); #1;

    // multiply with an ignored start mid-RUN
    do_op(F_MUL, 16'h0012, 16'h0034, 1'b0, 1'b0, 5, lat, bcnt);
    check("mul_res",   32'(result), 32'h03A8);
    check("mul_lat",   32'(lat),    32'd17);
    check("mul_busy",  32'(bcnt),   32'd16);
    check("mul_flags", 32'(flags),  32'h0);
    @(posedge clk); #1;
    check("mul_no_requeue_done", 32'(done), 32'h0);
    check("mul_no_requeue_busy", 32'(busy), 32'h0);

    // multiply overflow into upper bits
    do_op(F_MUL, 16'h0100, 16'h0100, 1'b0, 1'b0, -1, lat, bcnt);
    check("mulov_res",   32'(result), 32'h0000);
    check("mulov_flags", 32'(flags),  32'b1010);
    check("mulov_lat",   32'(lat),    32'd17);

    // shifts and logic ops, issued back to back
    do_op(F_SHL, 16'h8001, 16'h0000, 1'b0, 1'b0, -1, lat, bcnt);
    check("shl_res",   32'(result), 32'h0002);
    check("shl_flags", 32'(flags),  32'b0010);
    do_op(F_SHR, 16'h8001, 16'h0000, 1'b0, 1'b0, -1, lat, bcnt);
    check("shr_res",   32'(result), 32'h4000);
    check("shr_flags", 32'(flags),  32'b0010);
    do_op(F_NOTX, 16'h00FF, 16'h0000, 1'b0, 1'b0, -1, lat, bcnt);
    check("notx_res",   32'(result), 32'hFF00);
    check("notx_flags", 32'(flags),  32'b0100);
    do_op(F_AND, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, -1, lat, bcnt);
    check("and_res", 32'(result), 32'h00F0);
    do_op(F_OR, 16'hF000, 16'h000F, 1'b0, 1'b0, -1, lat, bcnt);
    check("or_res", 32'(result), 32'hF00F);
    do_op(F_NOTY, 16'h0000, 16'h1234, 1'b0, 1'b0, -1, lat, bcnt);
    check("noty_res", 32'(result), 32'hEDCB);
    check("noty_lat", 32'(lat),    32'd1);

    // illegal function selects
    do_op(11'b00000000011, 16'h0003, 16'h0004, 1'b0, 1'b0, -1, lat, bcnt);
    check("ill2_res",   32'(result), 32'h0000);
    check("ill2_flags", 32'(flags),  32'b1001);
    check("ill2_lat",   32'(lat),    32'd1);
    do_op(11'b00000000000, 16'h0003, 16'h0004, 1'b0, 1'b0, -1, lat, bcnt);
    check("ill0_flags", 32'(flags), 32'b1001);

    // operand zeroing
    do_op(F_ADD, 16'h1234, 16'h0005, 1'b1, 1'b0, -1, lat, bcnt);
    check("c7_res", 32'(result), 32'h0005);
    do_op(F_PASSY, 16'h1234, 16'hABCD, 1'b0, 1'b1, -1, lat, bcnt);
    check("c14_res",   32'(result), 32'h0000);
    check("c14_flags", 32'(flags),  32'b1000);

    // divide
`ifdef ALU_SEQ_DIV_EN
    do_op(F_DIV, 16'h0064, 16'h0007, 1'b0, 1'b0, -1, lat, bcnt);
    check("div_res",   32'(result), 32'h000E);
    check("div_lat",   32'(lat),    32'd17);
    check("div_flags", 32'(flags),  32'h0);
    do_op(F_DIV, 16'h0064, 16'h0000, 1'b0, 1'b0, -1, lat, bcnt);
    check("div0_res",   32'(result), 32'hFFFF);
    check("div0_flags", 32'(flags),  32'b0101);
    check("div0_lat",   32'(lat),    32'd17);
`else
    do_op(F_DIV, 16'h0064, 16'h0007, 1'b0, 1'b0, -1, lat, bcnt);
    check("nodiv_res",   32'(result), 32'h0000);
    check("nodiv_flags", 32'(flags),  32'b1001);
    check("nodiv_lat",   32'(lat),    32'd1);
`endif

    // back-to-back single-cycle ops: new start accepted in DONE
    do_op(F_ADD, 16'h0001, 16'h0001, 1'b0, 1'b0, -1, lat, bcnt);
    check("b2b1_res", 32'(result), 32'h0002);
    check("b2b1_done", 32'(done), 32'h1);
    do_op(F_SUB, 16'h0005, 16'h0001, 1'b0, 1'b0, -1, lat, bcnt);
    check("b2b2_res", 32'(result), 32'h0004);
    check("b2b2_lat", 32'(lat),    32'd1);
    @(posedge clk); #1;

    // reset in the middle of a multiply
    acc_in = 16'h0012; x_in = 16'h0034; fn = F_MUL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstrun_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("rstrun_busy",   32'(busy),   32'h0);
    check("rstrun_done",   32'(done),   32'h0);
    check("rstrun_result", 32'(result), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    dcount = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("rstrun_no_done", 32'(dcount), 32'd0);
    do_op(F_ADD, 16'h0010, 16'h0020, 1'b0, 1'b0, -1, lat, bcnt);
    check("post_rst_res", 32'(result), 32'h0030);
    check("post_rst_lat", 32'(lat),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
